// File: rtl/ov7670_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_pkg
// Description : Shared constants, state encoding and frame helpers for the
//               OV7670 SCCB configuration sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ov7670_pkg;

  localparam logic [7:0]  SCCB_WRITE_ID = 8'h42;
  localparam logic [15:0] ROM_END       = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY     = 16'hFFF0;
  localparam int          FRAME_BITS    = 27;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    START  = 4'd3,
    BITS   = 4'd4,
    STOP   = 4'd5,
    GAP    = 4'd6,
    DELAY  = 4'd7,
    DONE   = 4'd8
  } sccb_cfg_state_t;

  // Three-phase write frame, MSB first. The three ACK/don't-care slots hold 1
  // so the released line and the driven value agree.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [15:0] word);
    return {SCCB_WRITE_ID, 1'b1, word[15:8], 1'b1, word[7:0], 1'b1};
  endfunction

  // Bit positions (0-based, MSB first) where the master releases SIOD.
  function automatic logic is_ack_slot(input logic [4:0] bit_idx);
    return (bit_idx == 5'd8) || (bit_idx == 5'd17) || (bit_idx == 5'd26);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_qtr_tick.sv
`default_nettype none
// ============================================================================
// Module      : sccb_qtr_tick
// Description : Quarter-bit divider. Emits a 1-clock tick every QTR clocks
//               while not cleared; clearing realigns it to the start of a
//               bus phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sccb_qtr_tick #(
  parameter int QTR = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(QTR - 1));
  assign tick   = at_end && !clear;

  // Divider counter: wraps every QTR clocks, held at zero while cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module      : ov7670_sccb_config
// Description : Walks the camera configuration ROM from address 0 and writes
//               every entry to the OV7670 as an SCCB 3-phase write. FFF0
//               inserts a delay, FFFF ends the sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int SCCB_FREQ_HZ = 100_000,
  parameter int DELAY_CYCLES = 1_000_000   // must be at least 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  output logic        busy,
  output logic        done
);

  localparam int QTR = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int DW  = $clog2(DELAY_CYCLES + 1);

  sccb_cfg_state_t        state, state_n;
  logic [1:0]             qcnt, qcnt_n;
  logic [4:0]             bcnt, bcnt_n;
  logic [DW-1:0]          dcnt, dcnt_n;
  logic [FRAME_BITS-1:0]  shift, shift_n;
  logic [15:0]            rom_q, rom_q_n;
  logic [7:0]             addr_n;
  logic                   busy_n, done_n;
  logic                   sioc_n, siod_n, oe_n;
  logic                   qtr_clear, tick;

  // Quarter timing restarts each time a bus phase is entered from the
  // fetch/decode path, so START q0 always lasts a full QTR.
  assign qtr_clear = (state == IDLE) || (state == FETCH) || (state == DECODE);

  sccb_qtr_tick #(
    .QTR (QTR)
  ) u_qtr_tick (
    .clk   (clk),
    .reset (reset),
    .clear (qtr_clear),
    .tick  (tick)
  );

  // State register plus all datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      qcnt     <= 2'd0;
      bcnt     <= 5'd0;
      dcnt     <= '0;
      shift    <= '1;
      rom_q    <= 16'h0000;
      rom_addr <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      sioc     <= 1'b1;
      siod_o   <= 1'b1;
      siod_oe  <= 1'b0;
    end else begin
      state    <= state_n;
      qcnt     <= qcnt_n;
      bcnt     <= bcnt_n;
      dcnt     <= dcnt_n;
      shift    <= shift_n;
      rom_q    <= rom_q_n;
      rom_addr <= addr_n;
      busy     <= busy_n;
      done     <= done_n;
      sioc     <= sioc_n;
      siod_o   <= siod_n;
      siod_oe  <= oe_n;
    end
  end

  // Next-state logic; bus pins are decoded from the next state so they are
  // registered and glitch-free yet aligned with the state they belong to.
  always_comb begin
    state_n = state;
    qcnt_n  = qcnt;
    bcnt_n  = bcnt;
    dcnt_n  = dcnt;
    shift_n = shift;
    rom_q_n = rom_q;
    addr_n  = rom_addr;
    busy_n  = busy;
    done_n  = done;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          addr_n  = 8'h00;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          qcnt_n  = 2'd0;
          state_n = FETCH;
        end
      end

      // qcnt doubles as the ROM latency counter here.
      FETCH: begin
        if (qcnt == 2'd0) begin
          qcnt_n = 2'd1;
        end else begin
          qcnt_n  = 2'd0;
          rom_q_n = rom_data;
          state_n = DECODE;
        end
      end

      DECODE: begin
        qcnt_n = 2'd0;
        bcnt_n = 5'd0;
        if (rom_q == ROM_END) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end else if (rom_q == ROM_DELAY) begin
          dcnt_n  = '0;
          state_n = DELAY;
        end else begin
          shift_n = build_frame(rom_q);
          state_n = START;
        end
      end

      START: begin
        if (tick) begin
          qcnt_n = qcnt + 2'd1;
          if (qcnt == 2'd3) begin
            state_n = BITS;
          end
        end
      end

      BITS: begin
        if (tick) begin
          qcnt_n = qcnt + 2'd1;
          if (qcnt == 2'd3) begin
            if (bcnt == 5'(FRAME_BITS - 1)) begin
              state_n = STOP;
            end else begin
              bcnt_n  = bcnt + 5'd1;
              shift_n = {shift[FRAME_BITS-2:0], 1'b1};
            end
          end
        end
      end

      STOP: begin
        if (tick) begin
          qcnt_n = qcnt + 2'd1;
          if (qcnt == 2'd3) begin
            state_n = GAP;
          end
        end
      end

      GAP: begin
        if (tick) begin
          qcnt_n = qcnt + 2'd1;
          if (qcnt == 2'd3) begin
            if (rom_addr == 8'hFF) begin
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = DONE;
            end else begin
              addr_n  = rom_addr + 8'd1;
              state_n = FETCH;
            end
          end
        end
      end

      DELAY: begin
        if (dcnt == DW'(DELAY_CYCLES - 1)) begin
          qcnt_n = 2'd0;
          if (rom_addr == 8'hFF) begin
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            addr_n  = rom_addr + 8'd1;
            state_n = FETCH;
          end
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    // Bus pin decode: idle bus (SIOC high, SIOD released) unless framing.
    sioc_n = 1'b1;
    siod_n = 1'b1;
    oe_n   = 1'b0;
    case (state_n)
      START: begin
        oe_n   = 1'b1;
        sioc_n = (qcnt_n != 2'd3);
        siod_n = (qcnt_n == 2'd0);
      end
      BITS: begin
        sioc_n = (qcnt_n == 2'd1) || (qcnt_n == 2'd2);
        siod_n = shift_n[FRAME_BITS-1];
        oe_n   = !is_ack_slot(bcnt_n);
      end
      STOP: begin
        oe_n   = (qcnt_n != 2'd3);
        sioc_n = (qcnt_n != 2'd0);
        siod_n = (qcnt_n >= 2'd2);
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_sccb_config.sv
`default_nettype none
// ============================================================================
// Module      : tb_ov7670_sccb_config
// Description : Self-checking bench for ov7670_sccb_config. Expected SCCB
//               frames are queued when a sequence is launched and compared
//               as the bus monitor decodes them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ov7670_sccb_config;

  localparam int QTR    = 4;
  localparam int DLY    = 50;
  localparam int QTR_D  = 250;
  localparam int BUDGET = 5000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod_o, siod_oe, busy, done;

  logic        start_b = 1'b0;
  logic [7:0]  rom_addr_b;
  logic [15:0] rom_data_b;
  logic        sioc_b, siod_o_b, siod_oe_b, busy_b, done_b;

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [256];

  int          n_assert = 0;
  int          n_fail = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  addr_log[$];
  bit          both_high = 1'b0;

  ov7670_sccb_config #(
    .CLK_FREQ_HZ  (400_000),
    .SCCB_FREQ_HZ (25_000),
    .DELAY_CYCLES (DLY)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .sioc     (sioc),
    .siod_o   (siod_o),
    .siod_oe  (siod_oe),
    .busy     (busy),
    .done     (done)
  );

  ov7670_sccb_config dut_def (
    .clk      (clk),
    .reset    (reset),
    .start    (start_b),
    .rom_addr (rom_addr_b),
    .rom_data (rom_data_b),
    .sioc     (sioc_b),
    .siod_o   (siod_o_b),
    .siod_oe  (siod_oe_b),
    .busy     (busy_b),
    .done     (done_b)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous ROMs with 1-clock latency.
  always @(posedge clk) begin
    rom_data   <= rom_a[rom_addr];
    rom_data_b <= rom_b[rom_addr_b];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare one decoded frame against the oldest queued expectation.
  task automatic frame_done(input logic [26:0] fr, input logic [26:0] om);
    logic [23:0] e;
    check("frame_queued", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("frame_bytes", {8'h00, fr[26:19], fr[17:10], fr[8:1]}, {8'h00, e});
      check("frame_oe_mask", {5'd0, om}, {5'd0, {3{9'b111111110}}});
    end
  endtask

  // Bus monitor: start condition, then sample the line on each SIOC rise.
  logic        prev_sioc = 1'b1;
  logic        prev_line = 1'b1;
  logic        mon_line;
  bit          in_frame = 1'b0;
  int          nb = 0;
  logic [26:0] fr_sh, om_sh;

  always @(negedge clk) begin
    mon_line = siod_oe ? siod_o : 1'b1;
    if ((busy && done) || (busy_b && done_b)) both_high = 1'b1;
    if (reset) begin
      in_frame = 1'b0;
      nb = 0;
    end else if (!in_frame) begin
      if (sioc && prev_sioc && prev_line && !mon_line) begin
        in_frame = 1'b1;
        nb = 0;
      end
    end else if (sioc && !prev_sioc) begin
      fr_sh = {fr_sh[25:0], mon_line};
      om_sh = {om_sh[25:0], siod_oe};
      nb++;
      if (nb == 27) begin
        in_frame = 1'b0;
        frame_done(fr_sh, om_sh);
      end
    end
    prev_sioc = sioc;
    prev_line = mon_line;
  end

  task automatic load_rom(input logic [15:0] w0, input logic [15:0] w1,
                          input logic [15:0] w2);
    foreach (rom_a[i]) rom_a[i] = 16'hFFFF;
    rom_a[0] = w0;
    rom_a[1] = w1;
    rom_a[2] = w2;
  endtask

  // Launch a sequence on the QTR=4 instance. Cycle n counts edges from the
  // one after which start is driven; optionally pulse start again at poke.
  task automatic run_seq(input int poke, output int first_low,
                         output int done_at, output bit oe_seen);
    int n;
    first_low = -1;
    done_at   = -1;
    oe_seen   = 1'b0;
    n         = 0;
    addr_log.delete();
    start = 1'b1;
    while (done_at < 0 && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
      start = (poke > 0) && (n == poke);
      if (n == 1) begin
        check("start_addr", 32'(rom_addr), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_done", 32'(done), 32'd0);
      end
      if (poke > 0 && n == poke + 1) begin
        check("ignored_start_addr", 32'(rom_addr), 32'd1);
        check("ignored_start_busy", 32'(busy), 32'd1);
      end
      if (addr_log.size() == 0 || addr_log[$] != rom_addr) addr_log.push_back(rom_addr);
      if (!sioc && first_low < 0) first_low = n;
      if (siod_oe) oe_seen = 1'b1;
      if (done) done_at = n;
    end
    start = 1'b0;
  endtask

  int fl, da, nr, nf, r0, r1, f1, n;
  bit oes;
  logic pb;

  initial begin
    foreach (rom_b[i]) rom_b[i] = 16'hFFFF;
    rom_b[0] = 16'h1280;
    load_rom(16'h1280, 16'hFFFF, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_sioc", 32'(sioc), 32'd1);
    check("rst_siod_o", 32'(siod_o), 32'd1);
    check("rst_siod_oe", 32'(siod_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // One write then end marker.
    exp_q.push_back(24'h42_1280);
    run_seq(0, fl, da, oes);
    check("w1_done_at", 32'(da), 32'(120*QTR + 3 + 4));
    check("w1_first_sioc_low", 32'(fl), 32'(1 + 3 + 3*QTR));
    check("w1_addr_count", 32'(addr_log.size()), 32'd2);
    check("w1_addr_last", 32'(addr_log[$]), 32'd1);
    check("w1_busy_after", 32'(busy), 32'd0);
    check("w1_bus_idle", {30'd0, sioc, siod_oe}, 32'b10);
    check("w1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Delay marker, then a write, then end.
    load_rom(16'hFFF0, 16'h1100, 16'hFFFF);
    exp_q.push_back(24'h42_1100);
    run_seq(0, fl, da, oes);
    check("dly_first_sioc_low", 32'(fl), 32'(1 + 3 + DLY + 3 + 3*QTR));
    check("dly_done_at", 32'(da), 32'(1 + 3 + DLY + 3 + 120*QTR + 3));
    check("dly_queue_empty", 32'(exp_q.size()), 32'd0);

    // End marker only.
    load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
    run_seq(0, fl, da, oes);
    check("end_done_at", 32'(da), 32'd4);
    check("end_sioc_never_low", 32'(fl), 32'hFFFF_FFFF);
    check("end_oe_never", 32'(oes), 32'd0);

    // Two writes, start re-pulsed mid-sequence, then a full rerun.
    load_rom(16'h1280, 16'h3456, 16'hFFFF);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(24'h42_1280);
      exp_q.push_back(24'h42_3456);
      run_seq((k == 0) ? 600 : 0, fl, da, oes);
      check("two_done_at", 32'(da), 32'(1 + 2*(3 + 120*QTR) + 3));
      check("two_addr_last", 32'(addr_log[$]), 32'd2);
      check("two_addr_count", 32'(addr_log.size()), 32'd3);
      check("two_queue_empty", 32'(exp_q.size()), 32'd0);
    end

    // Reset during bit 10 of the first frame.
    load_rom(16'h1280, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(24'h42_1280);
    start = 1'b1;
    repeat (169) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_oe", 32'(siod_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_sioc", 32'(sioc), 32'd1);
    check("mid_rst_oe", 32'(siod_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(posedge clk);
    exp_q.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(24'h42_1280);
    run_seq(0, fl, da, oes);
    check("post_rst_done_at", 32'(da), 32'(120*QTR + 3 + 4));
    check("post_rst_addr_first", 32'(addr_log[0]), 32'd0);
    check("post_rst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Default parameters: SIOC shape during BITS and full write length.
    nr = 0; nf = 0; r0 = 0; r1 = 0; f1 = 0; n = 0; pb = 1'b1;
    start_b = 1'b1;
    while (!done_b && n < 40000) begin
      @(posedge clk); #1;
      n++;
      start_b = 1'b0;
      if (sioc_b && !pb) begin
        nr++;
        if (nr == 1) r0 = n;
        if (nr == 2) r1 = n;
      end
      if (!sioc_b && pb) begin
        nf++;
        if (nf == 2) f1 = n;
      end
      pb = sioc_b;
    end
    check("def_sioc_high", 32'(f1 - r0), 32'(2*QTR_D));
    check("def_sioc_period", 32'(r1 - r0), 32'(4*QTR_D));
    check("def_done_at", 32'(n), 32'(1 + 30003 + 3));
    check("def_busy_after", 32'(busy_b), 32'd0);

    check("busy_done_exclusive", 32'(both_high), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
